sa_job_arbiter: RTL and testbench

- Shares one systolic-array wrapper instance between NUM_REQ matrix-multiply requesters, e.g. per-head Q*K^T and score*V engines.
- Arbitrates round-robin and muxes the winner's X/W operands onto the SA inputs.
- Sequences the SA through clear/start/wait. Captures the result matrix and returns it with a done pulse and an error flag.
- Sits between the MHA head controllers and the SA wrapper.

---
 rtl/sa_job_arbiter.sv | 157 +++++++++++++++
 tb/tb_sa_job_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_job_arbiter.sv
// Round-robin job arbiter that time-shares one systolic-array wrapper between
// NUM_REQ requesters: grant, clear, start, wait for out-valid, capture, report.
module sa_job_arbiter #(
  parameter int D_W     = 16,
  parameter int SA_R    = 16,
  parameter int SA_C    = 16,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                            I_CLK,
  input  logic                            I_ASYN_RSTN,
  input  logic [NUM_REQ-1:0]              I_REQ,
  input  logic [NUM_REQ*SA_R*SA_C*D_W-1:0] I_X_MATRIX,
  input  logic [NUM_REQ*SA_C*SA_R*D_W-1:0] I_W_MATRIX,
  output logic [NUM_REQ-1:0]              O_GNT,
  output logic [NUM_REQ-1:0]              O_DONE,
  output logic                            O_ERR,
  output logic [SA_R*SA_C*D_W-1:0]        O_RESULT,
  output logic                            O_BUSY,
  output logic                            O_SA_SYNC_RSTN,
  output logic                            O_SA_START,
  output logic [SA_R*SA_C*D_W-1:0]        O_SA_X,
  output logic [SA_C*SA_R*D_W-1:0]        O_SA_W,
  input  logic                            I_SA_OUT_VLD,
  input  logic [SA_R*SA_C*D_W-1:0]        I_SA_OUT
);

  localparam int unsigned MW = SA_R * SA_C * D_W;
  localparam int unsigned NR = NUM_REQ;
  localparam int unsigned PW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_CLR   = 5'b00010,
    S_START = 5'b00100,
    S_WAIT  = 5'b01000,
    S_DONE  = 5'b10000
  } state_t;

  state_t            state_q;
  logic [NR-1:0]     gnt_q;
  logic [NR-1:0]     done_q;
  logic [PW-1:0]     owner_q;
  logic [PW-1:0]     ptr_q;
  logic [CW-1:0]     cnt_q;
  logic              err_q;
  logic [MW-1:0]     res_q;
  logic              sa_rstn_q;
  logic              sa_start_q;

  logic              pick_vld_d;
  logic [NR-1:0]     pick_oh_d;
  logic [PW-1:0]     pick_idx_d;
  logic [CW-1:0]     cnt_d;
  logic [MW-1:0]     sa_x_d;
  logic [MW-1:0]     sa_w_d;
  int unsigned       scan_idx;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    pick_vld_d = 1'b0;
    pick_oh_d  = '0;
    pick_idx_d = '0;
    scan_idx   = 0;
    for (int unsigned i = 0; i < NR; i++) begin
      scan_idx = (32'(ptr_q) + i) % NR;
      if (!pick_vld_d && I_REQ[PW'(scan_idx)]) begin
        pick_vld_d                 = 1'b1;
        pick_idx_d                 = PW'(scan_idx);
        pick_oh_d[PW'(scan_idx)]   = 1'b1;
      end
    end
  end

  assign cnt_d = cnt_q + 1'b1;

  always_comb begin
    sa_x_d = '0;
    sa_w_d = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (gnt_q[i]) begin
        sa_x_d = sa_x_d | I_X_MATRIX[i*MW +: MW];
        sa_w_d = sa_w_d | I_W_MATRIX[i*MW +: MW];
      end
    end
  end

  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      done_q     <= '0;
      owner_q    <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      res_q      <= '0;
      sa_rstn_q  <= 1'b1;
      sa_start_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pick_vld_d) begin
            gnt_q     <= pick_oh_d;
            owner_q   <= pick_idx_d;
            sa_rstn_q <= 1'b0;
            state_q   <= S_CLR;
          end
        end
        S_CLR: begin
          sa_rstn_q  <= 1'b1;
          sa_start_q <= 1'b1;
          state_q    <= S_START;
        end
        S_START: begin
          sa_start_q <= 1'b0;
          cnt_q      <= '0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_d;
          // A valid sampled on the timeout cycle still counts as success.
          if (I_SA_OUT_VLD) begin
            res_q   <= I_SA_OUT;
            err_q   <= 1'b0;
            done_q  <= gnt_q;
            state_q <= S_DONE;
          end else if (cnt_d == CW'(TIMEOUT)) begin
            err_q   <= 1'b1;
            done_q  <= gnt_q;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= '0;
          err_q   <= 1'b0;
          gnt_q   <= '0;
          ptr_q   <= (owner_q == PW'(NR - 1)) ? '0 : owner_q + 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign O_GNT          = gnt_q;
  assign O_DONE         = done_q;
  assign O_ERR          = err_q;
  assign O_RESULT       = res_q;
  assign O_BUSY         = (state_q != S_IDLE);
  assign O_SA_SYNC_RSTN = sa_rstn_q;
  assign O_SA_START     = sa_start_q;
  assign O_SA_X         = sa_x_d;
  assign O_SA_W         = sa_w_d;

endmodule

// File: tb/tb_sa_job_arbiter.sv
// Directed bench for sa_job_arbiter with a behavioural systolic-array model
// whose out-valid is sticky until the array's synchronous reset.
module tb_sa_job_arbiter;

  localparam int DW = 16;
  localparam int R  = 16;
  localparam int C  = 16;
  localparam int NR = 4;
  localparam int TO = 40;
  localparam int MW = R * C * DW;

  logic             clk;
  logic             rst_n;
  logic [NR-1:0]    req;
  logic [NR*MW-1:0] x_bus;
  logic [NR*MW-1:0] w_bus;
  logic [NR-1:0]    gnt;
  logic [NR-1:0]    done;
  logic             err;
  logic [MW-1:0]    result;
  logic             busy;
  logic             sa_rstn;
  logic             sa_start;
  logic [MW-1:0]    sa_x;
  logic [MW-1:0]    sa_w;
  logic             m_vld;
  logic [MW-1:0]    m_out;

  logic [MW-1:0]    xm [NR];
  logic [MW-1:0]    wm [NR];
  logic [MW-1:0]    exp_res;
  int               m_lat;
  int               m_cnt;
  logic             m_run;
  int               n_chk;
  int               n_fail;

  sa_job_arbiter #(
    .D_W    (DW),
    .SA_R   (R),
    .SA_C   (C),
    .NUM_REQ(NR),
    .TIMEOUT(TO)
  ) u_dut (
    .I_CLK         (clk),
    .I_ASYN_RSTN   (rst_n),
    .I_REQ         (req),
    .I_X_MATRIX    (x_bus),
    .I_W_MATRIX    (w_bus),
    .O_GNT         (gnt),
    .O_DONE        (done),
    .O_ERR         (err),
    .O_RESULT      (result),
    .O_BUSY        (busy),
    .O_SA_SYNC_RSTN(sa_rstn),
    .O_SA_START    (sa_start),
    .O_SA_X        (sa_x),
    .O_SA_W        (sa_w),
    .I_SA_OUT_VLD  (m_vld),
    .I_SA_OUT      (m_out)
  );

  always #5 clk = ~clk;

  function automatic logic [MW-1:0] matmul(input logic [MW-1:0] x, input logic [MW-1:0] w);
    logic [MW-1:0] r;
    logic [DW-1:0] xe;
    logic [DW-1:0] we;
    int            acc;
    r = '0;
    for (int i = 0; i < R; i++) begin
      for (int j = 0; j < C; j++) begin
        acc = 0;
        for (int k = 0; k < C; k++) begin
          xe  = x[(i*C+k)*DW +: DW];
          we  = w[(k*R+j)*DW +: DW];
          acc = acc + int'($signed(xe)) * int'($signed(we));
        end
        r[(i*C+j)*DW +: DW] = DW'(acc >>> 13);
      end
    end
    return r;
  endfunction

  // SA model: valid appears m_lat cycles after start (0 = never), sticky until sync reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld <= 1'b0;
      m_run <= 1'b0;
      m_cnt <= 0;
      m_out <= '0;
    end else if (!sa_rstn) begin
      m_vld <= 1'b0;
      m_run <= 1'b0;
      m_cnt <= 0;
    end else if (sa_start) begin
      m_run <= 1'b1;
      m_cnt <= 1;
    end else if (m_run) begin
      if (m_lat != 0 && m_cnt == m_lat - 1) begin
        m_vld <= 1'b1;
        m_out <= matmul(sa_x, sa_w);
        m_run <= 1'b0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic chk_mat(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    int first;
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      first = 0;
      for (int e = R*C-1; e >= 0; e--)
        if (act[e*DW +: DW] !== exp[e*DW +: DW]) first = e;
      $display("FAIL %s: element %0d actual %0h required %0h", nm, first,
               act[first*DW +: DW], exp[first*DW +: DW]);
    end
  endtask

  function automatic int oh2idx(input logic [NR-1:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < NR; i++) if (oh[i]) r = i;
    return r;
  endfunction

  typedef struct {
    logic [NR-1:0] req;
    int            lat;
    logic [NR-1:0] gnt;
    logic          err;
    int            cyc;   // negedges from START-high cycle to DONE-high cycle
    logic          drop;
  } vec_t;

  vec_t vecs [11];

  // Entered just after a negedge while the DUT is idle; leaves it in the same condition.
  task automatic run_vec(input int k);
    vec_t v;
    int   n;
    int   lows;
    int   m;
    int   extra;
    int   idx;
    v   = vecs[k];
    idx = oh2idx(v.gnt);
    req   = v.req;
    m_lat = v.lat;
    n = 0;
    lows = 0;
    do begin
      @(negedge clk);
      n++;
      if (!sa_rstn) lows++;
    end while (!sa_start && n < 20);
    chk($sformatf("v%0d start latency", k), 64'(n), 64'(2));
    chk($sformatf("v%0d sync-rst low cycles", k), 64'(lows), 64'(1));
    chk($sformatf("v%0d gnt", k), 64'(gnt), 64'(v.gnt));
    chk($sformatf("v%0d busy", k), 64'(busy), 64'(1));
    chk_mat($sformatf("v%0d sa_x", k), sa_x, xm[idx]);
    chk_mat($sformatf("v%0d sa_w", k), sa_w, wm[idx]);
    if (v.drop) req = '0;
    m = 0;
    extra = 0;
    do begin
      @(negedge clk);
      m++;
      if (sa_start || !sa_rstn) extra++;
    end while (done == '0 && m < 300);
    chk($sformatf("v%0d done delay", k), 64'(m), 64'(v.cyc));
    chk($sformatf("v%0d done", k), 64'(done), 64'(v.gnt));
    chk($sformatf("v%0d err", k), 64'(err), 64'(v.err));
    chk($sformatf("v%0d stray start/clr", k), 64'(extra), 64'(0));
    if (!v.err) exp_res = matmul(xm[idx], wm[idx]);
    chk_mat($sformatf("v%0d result", k), result, exp_res);
    @(negedge clk);
    chk($sformatf("v%0d done pulse width", k), 64'(done), 64'(0));
    chk($sformatf("v%0d gnt cleared", k), 64'(gnt), 64'(0));
    chk($sformatf("v%0d idle", k), 64'(busy), 64'(0));
    chk_mat($sformatf("v%0d idle sa_x", k), sa_x, '0);
  endtask

  initial begin
    int n;
    clk    = 1'b0;
    rst_n  = 1'b0;
    req    = '0;
    m_lat  = 0;
    n_chk  = 0;
    n_fail = 0;
    exp_res = '0;
    x_bus = '0;
    w_bus = '0;
    for (int r = 0; r < NR; r++) begin
      xm[r] = '0;
      wm[r] = '0;
      for (int i = 0; i < R; i++) begin
        for (int j = 0; j < C; j++) xm[r][(i*C+j)*DW +: DW] = DW'(r*1000 + i*16 + j);
        wm[r][(i*R+i)*DW +: DW] = (r % 2 == 1) ? 16'h4000 : 16'h2000;
      end
      x_bus[r*MW +: MW] = xm[r];
      w_bus[r*MW +: MW] = wm[r];
    end

    //          req      lat   gnt      err   cyc drop
    vecs[0]  = '{4'b0001, 31, 4'b0001, 1'b0, 32, 1'b0};
    vecs[1]  = '{4'b1111,  5, 4'b0010, 1'b0,  6, 1'b0};
    vecs[2]  = '{4'b1111,  5, 4'b0100, 1'b0,  6, 1'b0};
    vecs[3]  = '{4'b1111,  5, 4'b1000, 1'b0,  6, 1'b0};
    vecs[4]  = '{4'b1111,  5, 4'b0001, 1'b0,  6, 1'b0};
    vecs[5]  = '{4'b1111,  5, 4'b0010, 1'b0,  6, 1'b0};
    vecs[6]  = '{4'b1111,  0, 4'b0100, 1'b1, 41, 1'b0};
    vecs[7]  = '{4'b1111, 40, 4'b1000, 1'b0, 41, 1'b0};
    vecs[8]  = '{4'b1111, 41, 4'b0001, 1'b1, 41, 1'b0};
    vecs[9]  = '{4'b0010,  3, 4'b0010, 1'b0,  4, 1'b1};
    vecs[10] = '{4'b0001,  2, 4'b0001, 1'b0,  3, 1'b0};

    repeat (2) @(negedge clk);
    chk("reset gnt", 64'(gnt), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset err", 64'(err), 64'(0));
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset sync_rstn", 64'(sa_rstn), 64'(1));
    chk("reset start", 64'(sa_start), 64'(0));
    chk_mat("reset result", result, '0);
    chk_mat("reset sa_x", sa_x, '0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 11; k++) run_vec(k);

    // Asynchronous reset while waiting on the array.
    req   = 4'b0100;
    m_lat = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sa_start && n < 20);
    chk("mid-rst job started", 64'(sa_start), 64'(1));
    repeat (3) @(negedge clk);
    chk("mid-rst in wait", 64'(busy), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid-rst gnt", 64'(gnt), 64'(0));
    chk("mid-rst busy", 64'(busy), 64'(0));
    chk("mid-rst start", 64'(sa_start), 64'(0));
    chk("mid-rst sync_rstn", 64'(sa_rstn), 64'(1));
    chk_mat("mid-rst result", result, '0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0011;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sa_start && n < 20);
    chk("post-rst start latency", 64'(n), 64'(2));
    chk("post-rst gnt ptr=0", 64'(gnt), 64'(4'b0001));
    req = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
